// File: rtl/tdm_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer.
package tdm_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } tdm_state_t;

  localparam int TDM_SLOTS = 4;
  localparam int TDM_SEL_W = 2;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot select counter: clear, load-to-1 (first slot already taken) and increment,
// with a flag marking the final slot of a frame.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load1_i,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [TDM_SEL_W-1:0] sel_o,
  output logic                 last_o
);

  logic [TDM_SEL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = '0;
    else if (load1_i) cnt_d = TDM_SEL_W'(1);
    else if (inc_i)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sel_o  = cnt_q;
  assign last_o = (cnt_q == TDM_SEL_W'(TDM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Serial-to-4-lane TDM demultiplexer with frame resync and idle timeout.
// Define TDM_DEMUX_FRAME_CHK_EN to add the frame_err strobe output.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic                 frame_start,
  output logic [TDM_SLOTS-1:0] out4,
  output logic                 out_valid,
  output logic [TDM_SEL_W-1:0] sel2,
  output logic                 busy
`ifdef TDM_DEMUX_FRAME_CHK_EN
  ,
  output logic                 frame_err
`endif
);

  tdm_state_t             state_q, state_d;
  logic [TDM_SLOTS-2:0]   shadow_q, shadow_d;
  logic [TDM_SLOTS-1:0]   out4_q, out4_d;
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             tcnt_q, tcnt_d;
  logic                   load1, inc, clr, last_slot, timeout_hit;
  logic [TDM_SEL_W-1:0]   sel;

  tdm_slot_ctr u_slot_ctr (
    .clk    (clk),
    .reset  (reset),
    .load1_i(load1),
    .inc_i  (inc),
    .clr_i  (clr),
    .sel_o  (sel),
    .last_o (last_slot)
  );

  // Abort fires on the idle cycle whose count would reach FRAME_TIMEOUT.
  assign timeout_hit = (state_q == COLLECT) && !in_valid &&
                       (tcnt_q == 8'(FRAME_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    out4_d      = out4_q;
    out_valid_d = 1'b0;
    tcnt_d      = tcnt_q;
    load1       = 1'b0;
    inc         = 1'b0;
    clr         = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && frame_start) begin
          shadow_d[0] = in_bit;
          load1       = 1'b1;
          tcnt_d      = '0;
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          tcnt_d = '0;
          if (frame_start) begin
            shadow_d[0] = in_bit;
            load1       = 1'b1;
          end else if (last_slot) begin
            out4_d      = {in_bit, shadow_q};
            out_valid_d = 1'b1;
            clr         = 1'b1;
            state_d     = IDLE;
          end else begin
            shadow_d[sel] = in_bit;
            inc           = 1'b1;
          end
        end else if (timeout_hit) begin
          tcnt_d  = '0;
          clr     = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      out4_q      <= '0;
      out_valid_q <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out4_q      <= out4_d;
      out_valid_q <= out_valid_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign out4      = out4_q;
  assign out_valid = out_valid_q;
  assign sel2      = sel;
  assign busy      = (state_q == COLLECT);

`ifdef TDM_DEMUX_FRAME_CHK_EN
  logic err_q, err_d;

  // Resync, stray bit while idle, or timeout abort.
  always_comb begin
    err_d = timeout_hit ||
            (in_valid && (state_q == IDLE)    && !frame_start) ||
            (in_valid && (state_q == COLLECT) &&  frame_start);
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign frame_err = err_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed scenarios plus random traffic against a frame-level model.
module tb_tdm_demux4;

  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       reset, in_bit, in_valid, frame_start;
  logic [3:0] out4;
  logic       out_valid, busy;
  logic [1:0] sel2;
`ifdef TDM_DEMUX_FRAME_CHK_EN
  logic       frame_err;
`endif

  int total = 0;
  int bad   = 0;

  // Frame-level reference model state
  bit   m_in_frame;
  int   m_bits[$];
  int   m_idle;
  logic [3:0] m_out4;
  bit   m_vld, m_err;

  always #5 clk = ~clk;

  tdm_demux4 #(.FRAME_TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .frame_start(frame_start),
    .out4       (out4),
    .out_valid  (out_valid),
    .sel2       (sel2),
    .busy       (busy)
`ifdef TDM_DEMUX_FRAME_CHK_EN
    ,
    .frame_err  (frame_err)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit fs, input bit b);
    m_vld = 0;
    m_err = 0;
    if (r) begin
      m_in_frame = 0;
      m_bits.delete();
      m_idle = 0;
      m_out4 = '0;
    end else if (v) begin
      m_idle = 0;
      if (fs) begin
        if (m_in_frame) m_err = 1;
        m_bits.delete();
        m_bits.push_back(int'(b));
        m_in_frame = 1;
      end else if (!m_in_frame) begin
        m_err = 1;
      end else begin
        m_bits.push_back(int'(b));
        if (m_bits.size() == 4) begin
          m_out4 = '0;
          for (int i = 0; i < 4; i++) m_out4 = m_out4 | 4'(m_bits[i] << i);
          m_vld = 1;
          m_in_frame = 0;
          m_bits.delete();
        end
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == TO) begin
        m_in_frame = 0;
        m_bits.delete();
        m_idle = 0;
        m_err = 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit fs, input bit b);
    reset = r; in_valid = v; frame_start = fs; in_bit = b;
    @(posedge clk);
    model_step(r, v, fs, b);
    #1;
    chk("out4", 8'(out4), 8'(m_out4));
    chk("out_valid", 8'(out_valid), 8'(m_vld));
    chk("sel2", 8'(sel2), m_in_frame ? 8'(m_bits.size()) : 8'd0);
    chk("busy", 8'(busy), 8'(m_in_frame));
`ifdef TDM_DEMUX_FRAME_CHK_EN
    chk("frame_err", 8'(frame_err), 8'(m_err));
`endif
  endtask

  // Full frame; bits[0] goes out with frame_start.
  task automatic frame(input logic [3:0] slots);
    for (int i = 0; i < 4; i++) cyc(0, 1, i == 0, slots[i]);
  endtask

  initial begin
    int vprob, fprob;
    reset = 1; in_bit = 0; in_valid = 0; frame_start = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 1);
    chk("rst_out4", 8'(out4), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    cyc(0, 0, 0, 0);

    // 1,0,1,1 -> 1101 with sel2 1,2,3,0
    cyc(0, 1, 1, 1); chk("seq_sel_a", 8'(sel2), 8'd1);
    cyc(0, 1, 0, 0); chk("seq_sel_b", 8'(sel2), 8'd2);
    cyc(0, 1, 0, 1); chk("seq_sel_c", 8'(sel2), 8'd3);
    cyc(0, 1, 0, 1); chk("seq_sel_d", 8'(sel2), 8'd0);
    chk("word_1101", 8'(out4), 8'b1101);
    chk("strobe_on", 8'(out_valid), 8'd1);
    cyc(0, 0, 0, 0); chk("strobe_off", 8'(out_valid), 8'd0);

    // Back-to-back frames
    frame(4'b0110); chk("word_0110", 8'(out4), 8'b0110);
    frame(4'b1111); chk("word_1111", 8'(out4), 8'b1111);

    // Resync mid-frame
    cyc(0, 1, 1, 1); cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 1); cyc(0, 1, 0, 0);
    chk("word_resync", 8'(out4), 8'b0100);

    // Timeout after two bits
    cyc(0, 1, 1, 1); cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("busy_pre_to", 8'(busy), 8'd1);
    cyc(0, 0, 0, 0);
    chk("busy_post_to", 8'(busy), 8'd0);
    chk("out4_kept", 8'(out4), 8'b0100);

    // Reset mid-frame, then a fresh frame
    cyc(0, 1, 1, 1); cyc(0, 1, 0, 1);
    cyc(1, 1, 0, 1);
    chk("mid_rst_sel", 8'(sel2), 8'd0);
    chk("mid_rst_out4", 8'(out4), 8'd0);
    frame(4'b0001); chk("word_0001", 8'(out4), 8'b0001);

    // Stray bits while idle
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 0); cyc(0, 1, 0, 1);
    chk("idle_busy", 8'(busy), 8'd0);

    // Random traffic in bursts of varying density
    for (int blk = 0; blk < 60; blk++) begin
      vprob = $urandom_range(20, 100);
      fprob = $urandom_range(5, 40);
      for (int i = 0; i < 50; i++) begin
        cyc(($urandom % 200) == 0,
            ($urandom % 100) < vprob,
            ($urandom % 100) < fprob,
            $urandom % 2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Time-division 1:4 demultiplexer. The receive end of the 4:1 bit-multiplexed link built from the MUX4x1/MUX2x1 tree: it takes one serial bit per valid cycle, steers it into lane slot 0..3 under a self-generated 2-bit select, and presents the reassembled 4-bit word in parallel with a one-cycle valid strobe. It sits between the serial link input and the parallel lane consumers.

## Interface
- FRAME_TIMEOUT, default 15: number of consecutive cycles without `in_valid` in COLLECT that aborts the frame; legal range 1..255.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_bit  input  1  serial data bit.
- in_valid  input  1  `in_bit` is valid this cycle.
- frame_start  input  1  qualifies `in_bit` as slot 0; ignored unless `in_valid`=1.
- out4  output  4  reassembled word; bit i = slot i.
- out_valid  output  1  one-cycle strobe, `out4` updated this cycle.
- sel2  output  2  next slot to be written (current select).
- busy  output  1  high while in COLLECT.
- frame_err  output  1  one-cycle error strobe; present only with the macro (see Configuration).

## Operation
- States: IDLE, COLLECT. Reset → IDLE, sel2=0, out4=0, out_valid=0, busy=0, frame_err=0, shadow=0, timeout count=0.
- Accept = `in_valid`=1. Non-accept cycles change nothing except the timeout count.
- IDLE: accept with `frame_start`=1 → shadow[0]=in_bit, sel2=1, → COLLECT. Accept without `frame_start` → bit dropped, stay IDLE.
- COLLECT: accept without `frame_start` → shadow[sel2]=in_bit, sel2+1. On slot 3 the word completes: out4={in_bit, shadow[2:0]}, out_valid=1, sel2=0, → IDLE.
- COLLECT, accept with `frame_start`=1 → the partial frame is discarded, the bit is taken as the new slot 0, sel2=1, stay COLLECT (resync).
- Timeout: the counter clears on every accept and on entering COLLECT. It increments on each non-accept cycle in COLLECT. When it reaches FRAME_TIMEOUT → abort, sel2=0, → IDLE, out4 unchanged.
- out4 holds its last complete word until the next completion. Partial or aborted frames never reach out4.
- Reset mid-frame: the partial frame is discarded and every output returns to its reset value on the next edge.

## Timing
- Latency: the fourth accepted bit, sampled at edge N, produces out4/out_valid valid right after edge N. Registered outputs; no combinational path from inputs to outputs.
- Back-to-back frames: the completing cycle returns to IDLE, so `frame_start` may be applied in the very next cycle. Minimum frame period is 4 cycles, giving one word every 4 cycles at full rate.
- The timeout abort takes effect at the edge on which the count reaches FRAME_TIMEOUT, i.e. FRAME_TIMEOUT idle cycles after the last accept.
- Simultaneous reset with any input: reset wins.

## Configuration
- `TDM_DEMUX_FRAME_CHK_EN` defined: the `frame_err` port exists. It pulses for one cycle on:
  - a resync (`frame_start` in COLLECT),
  - a timeout abort,
  - an accept without `frame_start` in IDLE.
- Undefined: the `frame_err` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `tdm_pkg`:
  - state enum `tdm_state_t` {IDLE, COLLECT};
  - constant `TDM_SLOTS`=4;
  - constant `TDM_SEL_W`=2.
- Sub-module `tdm_slot_ctr`: 2-bit slot counter with load-to-1, increment and clear. It provides `sel2` and a last-slot flag. The FSM, shadow register and timeout counter live in the top.

## Test plan
- Reset, then accepts 1/0/1/1 with `frame_start` on the first bit → out4=4'b1101, out_valid high for exactly 1 cycle, sel2 sequence 1,2,3,0.
- Two back-to-back frames, 0/1/1/0 then 1/1/1/1, with no gap → out4=4'b0110 then 4'b1111, strobes exactly 4 cycles apart.
- Frame of 1,1 then `frame_start` with bit 0 followed by 0,1,0 → out4=4'b0100. With the macro, frame_err pulses once at the resync.
- FRAME_TIMEOUT=3: two bits accepted, then 3 idle cycles → busy drops, out4 keeps its previous value, no out_valid; with the macro, frame_err pulses once.
- Reset asserted after 2 slots of a frame → next cycle: sel2=0, out4=0, busy=0. A following full frame 1/0/0/0 → out4=4'b0001.
- In IDLE, accepts without `frame_start` → no state change, no out_valid; with the macro, frame_err pulses once per dropped bit.
